// File: rtl/axi_pkg.sv
// Shared AXI constants and the SRAM-to-AXI bridge state encoding and request payload.
package axi_pkg;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;
  localparam int unsigned AXI_ID_W   = 4;
  localparam int unsigned AXI_LEN_W  = 8;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam logic [2:0] AXI_SIZE_BYTE = 3'd0;
  localparam logic [2:0] AXI_SIZE_HALF = 3'd1;
  localparam logic [2:0] AXI_SIZE_WORD = 3'd2;

  typedef enum logic [2:0] {
    BR_IDLE = 3'd0,
    BR_AR   = 3'd1,
    BR_R    = 3'd2,
    BR_AWW  = 3'd3,
    BR_B    = 3'd4
  } bridge_state_e;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_DATA_W-1:0] wdata;
    logic [1:0]            size;
    logic                  wr;
  } cache_req_t;

endpackage

// File: rtl/wstrb_gen.sv
// Write-strobe decode from access size and low address bits; shared by both cache-side bridges.
module wstrb_gen
  import axi_pkg::*;
(
  input  logic [1:0]            size,
  input  logic [1:0]            addr_lo,
  output logic [AXI_STRB_W-1:0] wstrb_c
);

  always_comb begin
    wstrb_c = 4'b1111;
    case (size)
      AXI_SIZE_BYTE[1:0]: wstrb_c = 4'b0001 << addr_lo;
      AXI_SIZE_HALF[1:0]: wstrb_c = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:            wstrb_c = 4'b1111;
    endcase
  end

endmodule

// File: rtl/d_sram_axi_bridge.sv
// Single-outstanding bridge from the data cache SRAM-like port to single-beat AXI4 reads/writes.
module d_sram_axi_bridge
  import axi_pkg::*;
#(
  parameter logic [AXI_ID_W-1:0] RD_ID = 4'd0,
  parameter logic [AXI_ID_W-1:0] WR_ID = 4'd1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cache_data_req,
  input  logic                  cache_data_wr,
  input  logic [1:0]            cache_data_size,
  input  logic [AXI_ADDR_W-1:0] cache_data_addr,
  input  logic [AXI_DATA_W-1:0] cache_data_wdata,
  output logic [AXI_DATA_W-1:0] cache_data_rdata,
  output logic                  cache_data_addr_ok,
  output logic                  cache_data_data_ok,
  output logic [AXI_ID_W-1:0]   arid,
  output logic [AXI_ADDR_W-1:0] araddr,
  output logic [AXI_LEN_W-1:0]  arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [AXI_ID_W-1:0]   rid,
  input  logic [AXI_DATA_W-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [AXI_ID_W-1:0]   awid,
  output logic [AXI_ADDR_W-1:0] awaddr,
  output logic [AXI_LEN_W-1:0]  awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [AXI_DATA_W-1:0] wdata,
  output logic [AXI_STRB_W-1:0] wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [AXI_ID_W-1:0]   bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  bridge_state_e state, state_nxt;
  cache_req_t    req_q;
  logic          aw_done, w_done;
  logic          aw_done_nxt, w_done_nxt;
  logic          aw_hs, w_hs;
  logic          unused_ok;

  // Response status and IDs carry no information with a single outstanding transaction.
  assign unused_ok = ^{rid, rlast, bid, rresp ^ AXI_RESP_OKAY, bresp ^ AXI_RESP_OKAY};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= BR_IDLE;
      req_q   <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_nxt;
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
      if (state == BR_IDLE && cache_data_req) begin
        req_q.addr  <= cache_data_addr;
        req_q.wdata <= cache_data_wdata;
        req_q.size  <= cache_data_size;
        req_q.wr    <= cache_data_wr;
      end
    end
  end

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;

  // Next state and cache-side handshake pulses.
  always_comb begin
    state_nxt          = state;
    aw_done_nxt        = aw_done;
    w_done_nxt         = w_done;
    cache_data_addr_ok = 1'b0;
    cache_data_data_ok = 1'b0;
    case (state)
      BR_IDLE: begin
        if (cache_data_req) state_nxt = cache_data_wr ? BR_AWW : BR_AR;
      end
      BR_AR: begin
        if (arready) begin
          cache_data_addr_ok = 1'b1;
          state_nxt          = BR_R;
        end
      end
      BR_R: begin
        if (rvalid) begin
          cache_data_data_ok = 1'b1;
          state_nxt          = BR_IDLE;
        end
      end
      BR_AWW: begin
        aw_done_nxt = aw_done | aw_hs;
        w_done_nxt  = w_done | w_hs;
        if (aw_done_nxt && w_done_nxt) begin
          cache_data_addr_ok = 1'b1;
          state_nxt          = BR_B;
          aw_done_nxt        = 1'b0;
          w_done_nxt         = 1'b0;
        end
      end
      BR_B: begin
        if (bvalid) begin
          cache_data_data_ok = 1'b1;
          state_nxt          = BR_IDLE;
        end
      end
      default: state_nxt = BR_IDLE;
    endcase
  end

  assign cache_data_rdata = rdata;

  assign arid    = RD_ID;
  assign araddr  = req_q.addr;
  assign arlen   = '0;
  assign arsize  = {1'b0, req_q.size};
  assign arburst = AXI_BURST_INCR;
  assign arvalid = (state == BR_AR);
  assign rready  = (state == BR_R);

  assign awid    = WR_ID;
  assign awaddr  = req_q.addr;
  assign awlen   = '0;
  assign awsize  = {1'b0, req_q.size};
  assign awburst = AXI_BURST_INCR;
  assign awvalid = (state == BR_AWW) && !aw_done;
  assign wvalid  = (state == BR_AWW) && !w_done;
  assign wdata   = req_q.wdata;
  assign wlast   = 1'b1;
  assign bready  = (state == BR_B);

  wstrb_gen u_wstrb_gen (
    .size    (req_q.size),
    .addr_lo (req_q.addr[1:0]),
    .wstrb_c (wstrb)
  );

endmodule
